shared_bus_arbiter: RTL and testbench

Parametrised successor to the single-master processor bus mux, for the N-core matrix-multiply datapath. Each of NUM_CORES cores requests the shared bus with its own source-select code. A round-robin arbiter with bounded hold grants one core, and that core's selected register is driven onto a registered bus. Narrow (8-bit) sources are zero-extended. Illegal select codes are flagged.

---
 rtl/bus_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 28 ++
 rtl/shared_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_shared_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the shared bus arbiter: width defaults, source codes, select type and arbitration states.
package bus_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NARROW_W_DEF = 8;
  localparam int NUM_SRC_DEF  = 17;
  localparam int SEL_W_DEF    = $clog2(NUM_SRC_DEF + 2);

  localparam int SRC_IDLE  = 0;
  localparam int SRC_IR    = 1;
  localparam int SRC_TR    = 2;
  localparam int SRC_DR    = 3;
  localparam int SRC_AC    = 4;
  localparam int SRC_R0    = 5;
  localparam int SRC_R1    = 6;
  localparam int SRC_R2    = 7;
  localparam int SRC_SR    = 8;
  localparam int SRC_CR    = 9;
  localparam int SRC_MAR   = 10;
  localparam int SRC_MDR   = 11;
  localparam int SRC_PC    = 12;
  localparam int SRC_SP    = 13;
  localparam int SRC_RROW  = 14;
  localparam int SRC_RCOL0 = 15;
  localparam int SRC_RCOL1 = 16;
  localparam int SRC_RCOL2 = 17;
  localparam int SRC_DIFF  = 18;

  // Operands of the difference code, as source numbers.
  localparam int DIFF_A = SRC_IR;
  localparam int DIFF_B = SRC_TR;

  typedef logic [SEL_W_DEF-1:0] sel_t;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] owner,
  output logic             any
);

  always_comb begin
    gnt   = '0;
    owner = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        owner    = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin shared bus with bounded hold, registered source mux and illegal-code flag.
// Optional difference source code enabled by defining BUS_DIFF_SRC_EN.
module shared_bus_arbiter
  import bus_pkg::*;
#(
  parameter int                 DATA_W      = DATA_W_DEF,
  parameter int                 NARROW_W    = NARROW_W_DEF,
  parameter int                 NUM_SRC     = NUM_SRC_DEF,
  parameter logic [NUM_SRC-1:0] NARROW_MASK = 17'h1E187,
  parameter int                 NUM_CORES   = 4,
  parameter int                 HOLD_MAX    = 8,
  localparam int                SEL_W       = $clog2(NUM_SRC + 2),
  localparam int                OWN_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CORES-1:0]       core_req,
  input  logic [NUM_CORES-1:0]       core_hold,
  input  logic [NUM_CORES*SEL_W-1:0] core_sel,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  output logic [DATA_W-1:0]          bus_data,
  output logic                       bus_valid,
  output logic [NUM_CORES-1:0]       bus_gnt,
  output logic [OWN_W-1:0]           bus_owner,
  output logic                       sel_err
);

  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     hold_cnt, cnt_nxt;
  logic [OWN_W-1:0]     rr_ptr, ptr_nxt;
  logic [NUM_CORES-1:0] arb_req, arb_gnt, gnt_nxt;
  logic [OWN_W-1:0]     arb_owner, owner_nxt;
  logic                 arb_any, grant_any;
  logic                 owner_keeps, others_req, retain;
  logic [SEL_W-1:0]     sel_v;
  logic [DATA_W-1:0]    mux_val;
  logic                 mux_err;
  logic [DATA_W-1:0]    src_n [NUM_SRC];

  rr_arbiter #(.N(NUM_CORES), .PTR_W(OWN_W)) u_rr (
    .req    (arb_req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .owner  (arb_owner),
    .any    (arb_any)
  );

  // Narrow sources drop their upper slice bits.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      src_n[k] = src_data[k*DATA_W +: DATA_W];
      if (NARROW_MASK[k]) src_n[k][DATA_W-1:NARROW_W] = '0;
    end
  end

  always_comb begin
    owner_keeps = (state != IDLE) && core_req[bus_owner] && core_hold[bus_owner];
    others_req  = |(core_req & ~bus_gnt);
    retain      = owner_keeps && ((hold_cnt != CNT_LAST) || !others_req);
    // An expired holder is excluded so the grant really moves on.
    arb_req     = (owner_keeps && !retain) ? (core_req & ~bus_gnt) : core_req;

    state_nxt = IDLE;
    gnt_nxt   = '0;
    owner_nxt = bus_owner;
    cnt_nxt   = '0;
    grant_any = 1'b0;
    if (retain) begin
      state_nxt = HOLD;
      gnt_nxt   = bus_gnt;
      grant_any = 1'b1;
      cnt_nxt   = (hold_cnt == CNT_LAST) ? hold_cnt : hold_cnt + 1'b1;
    end else if (arb_any) begin
      state_nxt = GRANT;
      gnt_nxt   = arb_gnt;
      owner_nxt = arb_owner;
      grant_any = 1'b1;
    end
    ptr_nxt = (owner_nxt == OWN_W'(NUM_CORES - 1)) ? '0 : owner_nxt + 1'b1;

    sel_v   = core_sel[int'(owner_nxt)*SEL_W +: SEL_W];
    mux_val = '0;
    mux_err = 1'b0;
    if (int'(sel_v) > NUM_SRC + 1) begin
      mux_err = 1'b1;
    end else if (int'(sel_v) == NUM_SRC + 1) begin
`ifdef BUS_DIFF_SRC_EN
      mux_val = src_n[DIFF_A-1] - src_n[DIFF_B-1];
`else
      mux_err = 1'b1;
`endif
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        if (int'(sel_v) == k) mux_val = src_n[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      rr_ptr    <= '0;
      bus_data  <= '0;
      bus_valid <= 1'b0;
      bus_gnt   <= '0;
      bus_owner <= '0;
      sel_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= cnt_nxt;
      bus_gnt   <= gnt_nxt;
      bus_owner <= owner_nxt;
      bus_valid <= grant_any;
      sel_err   <= grant_any && mux_err;
      if (grant_any) begin
        bus_data <= mux_val;
        rr_ptr   <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Self-checking bench for shared_bus_arbiter: directed steps plus randomized traffic against a behavioural model.
module tb_shared_bus_arbiter;

  localparam int N        = 4;
  localparam int SW       = 5;
  localparam int DW       = 16;
  localparam int NSRC     = 17;
  localparam int HOLD_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      core_req;
  logic [N-1:0]      core_hold;
  logic [N*SW-1:0]   core_sel;
  logic [NSRC*DW-1:0] src_data;
  logic [DW-1:0]     bus_data;
  logic              bus_valid;
  logic [N-1:0]      bus_gnt;
  logic [1:0]        bus_owner;
  logic              sel_err;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int          m_owner;
  int          m_cnt;
  int          m_ptr;
  logic [15:0] m_data;
  bit          m_valid;
  bit          m_err;
  logic [16:0] nmask = 17'h1E187;

  shared_bus_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core_req  (core_req),
    .core_hold (core_hold),
    .core_sel  (core_sel),
    .src_data  (src_data),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .bus_gnt   (bus_gnt),
    .bus_owner (bus_owner),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sel(input int c, input int code);
    core_sel[c*SW +: SW] = SW'(code);
  endtask

  task automatic set_src(input int k, input logic [15:0] v);
    src_data[(k-1)*DW +: DW] = v;
  endtask

  function automatic logic [15:0] narrowed(input int k);
    logic [15:0] w;
    w = src_data[(k-1)*DW +: DW];
    if (nmask[k-1]) w = w & 16'h00FF;
    return w;
  endfunction

  function automatic logic [15:0] model_val(input int code, output bit err);
    err = 0;
    if (code == 0) return 16'h0;
    if (code <= NSRC) return narrowed(code);
`ifdef BUS_DIFF_SRC_EN
    if (code == NSRC + 1) return narrowed(1) - narrowed(2);
`endif
    err = 1;
    return 16'h0;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    m_data  = '0;
    m_valid = 0;
    m_err   = 0;
  endtask

  task automatic model_edge();
    bit keep, others, err;
    int nxt;
    keep = 0;
    if (m_owner >= 0) keep = core_req[m_owner] && core_hold[m_owner];
    others = 0;
    for (int i = 0; i < N; i++) if (i != m_owner && core_req[i]) others = 1;
    if (keep && (m_cnt < HOLD_MAX - 1 || !others)) begin
      nxt = m_owner;
      if (m_cnt < HOLD_MAX - 1) m_cnt++;
    end else begin
      nxt = -1;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (nxt < 0 && core_req[c] && !(keep && c == m_owner)) nxt = c;
      end
      m_cnt = 0;
    end
    m_owner = nxt;
    if (nxt >= 0) begin
      m_ptr   = (nxt + 1) % N;
      m_data  = model_val(int'(core_sel[nxt*SW +: SW]), err);
      m_err   = err;
      m_valid = 1;
    end else begin
      m_valid = 0;
      m_err   = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(bus_valid), 32'(m_valid));
    chk({tag, "_gnt"}, 32'(bus_gnt), m_valid ? (32'd1 << m_owner) : 32'd0);
    if (m_valid) chk({tag, "_owner"}, 32'(bus_owner), 32'(m_owner));
    chk({tag, "_data"}, 32'(bus_data), 32'(m_data));
    chk({tag, "_err"}, 32'(sel_err), 32'(m_err));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, 32'(bus_data), 32'd0);
    chk({tag, "_valid"}, 32'(bus_valid), 32'd0);
    chk({tag, "_gnt"}, 32'(bus_gnt), 32'd0);
    chk({tag, "_owner"}, 32'(bus_owner), 32'd0);
    chk({tag, "_err"}, 32'(sel_err), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero(tag);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_own [5];
    rst_n     = 1'b0;
    core_req  = '0;
    core_hold = '0;
    core_sel  = '0;
    src_data  = '0;
    do_reset("rst0");

    // basic grant of core0 from source 1
    set_src(1, 16'd11);
    set_sel(0, 1);
    core_req = 4'b0001;
    step("t1");
    chk("t1_data_c", 32'(bus_data), 32'd11);
    chk("t1_gnt_c", 32'(bus_gnt), 32'h1);
    chk("t1_valid_c", 32'(bus_valid), 32'd1);

    // narrow vs wide
    set_src(1, 16'hFFFE);
    step("t2n");
    chk("t2_narrow", 32'(bus_data), 32'h00FE);
    set_sel(0, 4);
    set_src(4, 16'hFFFE);
    step("t2w");
    chk("t2_wide", 32'(bus_data), 32'hFFFE);
    set_sel(0, 0);
    step("t2z");
    chk("t2_code0", 32'(bus_data), 32'h0);
    set_sel(0, 4);
    core_req = '0;
    step("t2idle");
    chk("t2_idle_valid", 32'(bus_valid), 32'd0);
    chk("t2_idle_keep", 32'(bus_data), 32'h0);

    // round robin with everyone requesting
    do_reset("rst1");
    for (int c = 0; c < N; c++) begin
      set_sel(c, 5 + c);
      set_src(5 + c, 16'h1000 + 16'(c));
    end
    core_req  = 4'b1111;
    core_hold = 4'b0000;
    exp_own = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      step("t3");
      chk("t3_owner_c", 32'(bus_owner), 32'(exp_own[i]));
    end

    // bounded hold with a waiter, then unbounded hold alone
    core_req  = 4'b0110;
    core_hold = 4'b0010;
    for (int i = 0; i < HOLD_MAX; i++) begin
      step("t4h");
      chk("t4_hold_owner", 32'(bus_owner), 32'd1);
    end
    step("t4r");
    chk("t4_rotate_owner", 32'(bus_owner), 32'd2);
    core_req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step("t4a");
      chk("t4_alone_owner", 32'(bus_owner), 32'd1);
    end

    // illegal and difference codes, changing source mid-hold
    set_sel(1, 19);
    step("t5i");
    chk("t5_ill_err", 32'(sel_err), 32'd1);
    chk("t5_ill_data", 32'(bus_data), 32'd0);
    set_src(1, 16'd2);
    set_src(2, 16'd7);
    set_sel(1, 18);
    step("t5d");
`ifdef BUS_DIFF_SRC_EN
    chk("t5_diff_data", 32'(bus_data), 32'hFFFB);
    chk("t5_diff_err", 32'(sel_err), 32'd0);
`else
    chk("t5_diff_err", 32'(sel_err), 32'd1);
    chk("t5_diff_data", 32'(bus_data), 32'd0);
`endif
    set_sel(1, 31);
    step("t5x");
    chk("t5_ill31_err", 32'(sel_err), 32'd1);

    // asynchronous reset during hold
    set_sel(1, 4);
    step("t6pre");
    do_reset("t6rst");
    core_req  = 4'b1111;
    core_hold = 4'b0000;
    step("t6");
    chk("t6_first_owner", 32'(bus_owner), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      core_req  = 4'($urandom_range(0, 15));
      core_hold = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0) set_sel(c, int'($urandom_range(19, 31)));
        else set_sel(c, int'($urandom_range(0, 18)));
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 1; k <= NSRC; k++) set_src(k, 16'($urandom));
      end
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
